writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/wb_pkg.sv | 14 +
 rtl/writeback_arbiter_if.sv | 27 ++
 rtl/wb_fifo.sv | 41 ++++
 rtl/writeback_arbiter.sv | 58 +++++
 tb/tb_writeback_arbiter.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, reserved register index and queue-entry type for the writeback arbiter
package wb_pkg;
    localparam logic [3:0] REG_PC = 4'hF;
    localparam int DATA_W = 32;
    localparam int IDX_W = 4;
    typedef struct packed {
        logic valid;
        logic [IDX_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
    function automatic logic is_pc(input logic [IDX_W-1:0] d);
        return d == REG_PC;
    endfunction
endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU/load write offers, hazard queries and register-file write port
interface writeback_arbiter_if;
    import wb_pkg::*;
    logic alu_valid;
    logic [IDX_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_result;
    logic alu_ready;
    logic ld_valid;
    logic [IDX_W-1:0] ld_dest;
    logic [DATA_W-1:0] ld_data;
    logic [IDX_W-1:0] src1;
    logic [IDX_W-1:0] src2;
    logic hazard1;
    logic hazard2;
    logic wb_en;
    logic [IDX_W-1:0] wb_dest;
    logic [DATA_W-1:0] wb_result;
    logic [2:0] q_count;
    modport master (
        output alu_valid, alu_dest, alu_result, ld_valid, ld_dest, ld_data, src1, src2,
        input alu_ready, hazard1, hazard2, wb_en, wb_dest, wb_result, q_count
    );
    modport slave (
        input alu_valid, alu_dest, alu_result, ld_valid, ld_dest, ld_data, src1, src2,
        output alu_ready, hazard1, hazard2, wb_en, wb_dest, wb_result, q_count
    );
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: compacting FIFO of pending ALU writes; squashed entries are removed so slot 0 is always the head
module wb_fifo import wb_pkg::*; #(
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    input logic push,
    input wb_entry_t push_ent,
    input logic pop,
    input logic inv,
    input logic [IDX_W-1:0] inv_dest,
    output logic [2:0] count,
    output wb_entry_t head,
    output logic [DEPTH-1:0] vld,
    output logic [DEPTH-1:0][IDX_W-1:0] dests
);
    wb_entry_t [DEPTH-1:0] q_q, q_d;
    always_comb begin
        int k;
        q_d = '0;
        count = '0;
        k = 0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + 3'(q_q[i].valid);
            vld[i] = q_q[i].valid;
            dests[i] = q_q[i].dest;
        end
        // survivors slide down in order; the push lands right after the last survivor
        for (int i = 0; i < DEPTH; i++) begin
            if (q_q[i].valid && !(pop && i == 0) && !(inv && q_q[i].dest == inv_dest)) begin
                for (int j = 0; j < DEPTH; j++) q_d[j] = (j == k) ? q_q[i] : q_d[j];
                k = k + 1;
            end
        end
        for (int j = 0; j < DEPTH; j++) q_d[j] = (push && j == k) ? push_ent : q_d[j];
    end
    assign head = q_q[0];
    always_ff @(posedge clk) begin
        q_q <= rst ? '0 : q_d;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: one register-file write per cycle, load > queued ALU > ALU bypass, with hazard lookup
module writeback_arbiter import wb_pkg::*; #(
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    writeback_arbiter_if.slave bus
);
    wb_entry_t head, push_ent;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0][IDX_W-1:0] dests;
    logic [2:0] cnt;
    logic alu_ready, alu_acc, alu_eff, ld_eff, pop, bypass, push, hz1, hz2;
    logic wb_en_d, wb_en_q;
    logic [IDX_W-1:0] wb_dest_d, wb_dest_q;
    logic [DATA_W-1:0] wb_result_d, wb_result_q;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .push_ent(push_ent), .pop(pop),
        .inv(ld_eff), .inv_dest(bus.ld_dest), .count(cnt), .head(head), .vld(vld), .dests(dests)
    );
    always_comb begin
        alu_ready = rst || cnt < 3'(DEPTH);
        alu_acc = bus.alu_valid && alu_ready;
        alu_eff = alu_acc && !is_pc(bus.alu_dest);
        ld_eff = bus.ld_valid && !is_pc(bus.ld_dest);
        pop = !ld_eff && head.valid;
        bypass = !ld_eff && cnt == 0 && alu_eff;
        push = alu_eff && !bypass;
        push_ent = '{valid: 1'b1, dest: bus.alu_dest, data: bus.alu_result};
        wb_en_d = ld_eff || pop || bypass;
        wb_dest_d = ld_eff ? bus.ld_dest : pop ? head.dest : bypass ? bus.alu_dest : wb_dest_q;
        wb_result_d = ld_eff ? bus.ld_data : pop ? head.data : bypass ? bus.alu_result : wb_result_q;
    end
    always_comb begin
        hz1 = (wb_en_q && wb_dest_q == bus.src1) || (alu_acc && bus.alu_dest == bus.src1) ||
              (bus.ld_valid && bus.ld_dest == bus.src1);
        hz2 = (wb_en_q && wb_dest_q == bus.src2) || (alu_acc && bus.alu_dest == bus.src2) ||
              (bus.ld_valid && bus.ld_dest == bus.src2);
        for (int i = 0; i < DEPTH; i++) begin
            hz1 = hz1 || (vld[i] && dests[i] == bus.src1);
            hz2 = hz2 || (vld[i] && dests[i] == bus.src2);
        end
        hz1 = hz1 && !is_pc(bus.src1);
        hz2 = hz2 && !is_pc(bus.src2);
    end
    always_ff @(posedge clk) begin
        wb_en_q <= rst ? 1'b0 : wb_en_d;
        wb_dest_q <= rst ? '0 : wb_dest_d;
        wb_result_q <= rst ? '0 : wb_result_d;
    end
    assign bus.alu_ready = alu_ready;
    assign bus.hazard1 = hz1;
    assign bus.hazard2 = hz2;
    assign bus.wb_en = wb_en_q;
    assign bus.wb_dest = wb_dest_q;
    assign bus.wb_result = wb_result_q;
    assign bus.q_count = cnt;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and random writes checked against a queue-based reference via a scoreboard
module tb_writeback_arbiter;
    localparam int DEPTH = 2;
    typedef struct packed {logic [3:0] d; logic [31:0] v;} ent_t;
    typedef struct packed {logic en; logic [3:0] d; logic [31:0] v;} exp_t;
    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int errors = 0;
    ent_t mq[$];
    exp_t exp_q[$];
    exp_t mon_e;
    logic m_en = 0;
    logic [3:0] m_dest = 0;
    logic [31:0] m_data = 0;
    writeback_arbiter_if bus();
    writeback_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic pend(input logic [3:0] s, input logic a, input logic [3:0] ad,
                                  input logic lv, input logic [3:0] ldd);
        if (s == 4'hF) return 1'b0;
        foreach (mq[i]) if (mq[i].d == s) return 1'b1;
        return (m_en && m_dest == s) || (a && ad == s) || (lv && ldd == s);
    endfunction

    // One register-file write slot per cycle; a load squashes older queued writes to the same register
    task automatic step(input logic r, input logic av, input logic [3:0] ad, input logic [31:0] ar,
                        input logic lv, input logic [3:0] ldd, input logic [31:0] ldt,
                        input logic [3:0] s1, input logic [3:0] s2, output logic acc);
        logic rdy, a, taken;
        ent_t ne, tmp[$];
        @(negedge clk);
        rst = r;
        bus.alu_valid = av; bus.alu_dest = ad; bus.alu_result = ar;
        bus.ld_valid = lv; bus.ld_dest = ldd; bus.ld_data = ldt;
        bus.src1 = s1; bus.src2 = s2;
        #1;
        acc = 0;
        if (r) begin
            chk("alu_ready_in_reset", 32'(bus.alu_ready), 32'd1);
            mq.delete();
            m_en = 0; m_dest = 0; m_data = 0;
        end else begin
            rdy = mq.size() < DEPTH;
            a = av && rdy;
            chk("alu_ready", 32'(bus.alu_ready), 32'(rdy));
            chk("q_count", 32'(bus.q_count), 32'(mq.size()));
            chk("hazard1", 32'(bus.hazard1), 32'(pend(s1, a, ad, lv, ldd)));
            chk("hazard2", 32'(bus.hazard2), 32'(pend(s2, a, ad, lv, ldd)));
            m_en = 1; taken = 0;
            if (lv && ldd != 4'hF) begin
                m_dest = ldd; m_data = ldt;
                foreach (mq[i]) if (mq[i].d != ldd) tmp.push_back(mq[i]);
                mq = tmp;
            end else if (mq.size() != 0) begin
                ne = mq.pop_front();
                m_dest = ne.d; m_data = ne.v;
            end else if (a && ad != 4'hF) begin
                m_dest = ad; m_data = ar; taken = 1;
            end else m_en = 0;
            if (a && ad != 4'hF && !taken) begin
                ne.d = ad; ne.v = ar;
                mq.push_back(ne);
            end
            acc = a;
        end
        exp_q.push_back({m_en, m_dest, m_data});
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("wb_en", 32'(bus.wb_en), 32'(mon_e.en));
            chk("wb_dest", 32'(bus.wb_dest), 32'(mon_e.d));
            chk("wb_result", bus.wb_result, mon_e.v);
        end
    end

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'hF, acc);
    endtask

    initial begin
        logic acc;
        int v;
        logic [3:0] ad, ldd;
        bus.alu_valid = 0; bus.alu_dest = 0; bus.alu_result = 0;
        bus.ld_valid = 0; bus.ld_dest = 0; bus.ld_data = 0;
        bus.src1 = 4'hF; bus.src2 = 4'hF;
        step(1, 0, 0, 0, 0, 0, 0, 4'hF, 4'hF, acc);
        step(1, 1, 2, 32'h9, 0, 0, 0, 4'hF, 4'hF, acc);
        idle(1);
        // ALU bypass on an idle block
        step(0, 1, 3, 32'h11, 0, 0, 0, 3, 4'hF, acc);
        idle(2);
        // load and ALU in the same cycle
        step(0, 1, 6, 32'hBB, 1, 5, 32'hAA, 5, 6, acc);
        idle(3);
        // back-pressure: loads for 4 cycles while the ALU keeps offering until accepted
        v = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 4'(8 + v), 32'h100 + 32'(v), 1, 4'(i), 32'h200 + 32'(i), 4'(8 + v), 4'hF, acc);
            if (acc) v++;
        end
        while (v < 5) begin
            step(0, 1, 4'(8 + v), 32'h100 + 32'(v), 0, 0, 0, 8, 9, acc);
            if (acc) v++;
        end
        idle(4);
        // squash a queued write by a younger load to the same register
        step(0, 1, 7, 32'h1, 1, 1, 32'h55, 7, 4'hF, acc);
        step(0, 0, 0, 0, 1, 7, 32'h2, 7, 4'hF, acc);
        idle(3);
        // writes to R15 are discarded; src 15 never reports a hazard
        step(0, 1, 4'hF, 32'h77, 0, 0, 0, 4'hF, 4'hF, acc);
        step(0, 0, 0, 0, 1, 4'hF, 32'h78, 4'hF, 4'hF, acc);
        idle(1);
        // hazard on a pending queued write until it commits
        step(0, 1, 5, 32'h5, 1, 1, 32'h6, 5, 4'hF, acc);
        step(0, 0, 0, 0, 1, 2, 32'h7, 5, 4'hF, acc);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 5, 4'hF, acc);
        // reset while the queue holds two entries
        step(0, 1, 10, 32'hA0, 1, 1, 32'h1, 4'hF, 4'hF, acc);
        step(0, 1, 11, 32'hB0, 1, 2, 32'h2, 4'hF, 4'hF, acc);
        step(1, 1, 12, 32'hC0, 1, 3, 32'h3, 4'hF, 4'hF, acc);
        idle(2);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            ad = 4'($urandom_range(0, 15));
            ldd = 4'($urandom_range(0, 15));
            if (ldd == ad) ldd = ldd ^ 4'h1;
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), ad, $urandom,
                 ($urandom_range(0, 2) == 0), ldd, $urandom,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), acc);
        end
        idle(6);
        @(negedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
